demux_1x4_2bit_reg: RTL

- Inverse-direction companion to the board-level 4-to-1 2-bit selector: takes one 2-bit value from switches and routes it into one of four 2-bit channel registers selected by a 2-bit address.
- Commits a write on a debounced rising edge of a write switch.
- Channel contents, per-channel valid flags and a write-acknowledge pulse drive board LEDs.
- Sits at board top level beside the selector, sharing the same switch/LED pin set.

---
 rtl/mux_pkg.sv | 14 +
 rtl/demux_1x4_2bit_reg_switch_debounce.sv | 37 +++
 rtl/demux_1x4_2bit_reg.sv | 93 +++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Constants and state encoding shared by the 4-to-1 selector and the 1-to-4 demux.
package mux_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } mux_state_t;

endpackage

// File: rtl/demux_1x4_2bit_reg_switch_debounce.sv
// Two-flop synchronizer followed by a stability counter; stable only follows
// the synchronized level after DEBOUNCE_CYCLES consecutive differing samples.
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic stable
);

  logic        sync1;
  logic        sync2;
  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      // Any sample agreeing with the accepted level restarts the count.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == 16'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/demux_1x4_2bit_reg.sv
// Routes a switch-selected 2-bit value into one of four channel registers on a
// debounced write edge; channel bank, valid flags and a write ack drive LEDs.
//
// state | meaning
// IDLE  | waiting for debounced write switch to rise
// WRITE | one cycle: commit synced data into channel sel, load ack timer
// HOLD  | waiting for write switch release; no further writes
module demux_1x4_2bit_reg
  import mux_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int ACK_CYCLES      = 500000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CH_W-1:0]        sw_data,
  input  logic [SEL_W-1:0]       sw_sel,
  input  logic                   sw_wr,
  input  logic                   sw_clr,
  output logic [NUM_CH*CH_W-1:0] led,
  output logic [NUM_CH-1:0]      led_vld,
  output logic                   led_ack
);

  localparam int ACK_W = $clog2(ACK_CYCLES + 1);

  logic [CH_W-1:0]  data_s1, data_s2;
  logic [SEL_W-1:0] sel_s1, sel_s2;
  logic             wr_stable;
  logic             clr_stable;
  mux_state_t       state;
  logic [ACK_W-1:0] ack_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_s1 <= '0;
      data_s2 <= '0;
      sel_s1  <= '0;
      sel_s2  <= '0;
    end else begin
      data_s1 <= sw_data;
      data_s2 <= data_s1;
      sel_s1  <= sw_sel;
      sel_s2  <= sel_s1;
    end
  end

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_wr_db (
    .clk    (clk),
    .rst    (rst),
    .sw     (sw_wr),
    .stable (wr_stable)
  );

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
    .clk    (clk),
    .rst    (rst),
    .sw     (sw_clr),
    .stable (clr_stable)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      led     <= '0;
      led_vld <= '0;
      ack_cnt <= '0;
    end else begin
      if (ack_cnt != '0) ack_cnt <= ack_cnt - ACK_W'(1);
      case (state)
        IDLE: if (wr_stable) state <= WRITE;
        WRITE: begin
          ack_cnt <= ACK_W'(ACK_CYCLES);
          state   <= HOLD;
          if (!clr_stable) begin
            led[int'(sel_s2)*CH_W +: CH_W] <= data_s2;
            led_vld[sel_s2]                <= 1'b1;
          end
        end
        HOLD: if (!wr_stable) state <= IDLE;
        default: state <= IDLE;
      endcase
      // Clear wins over a coincident write but leaves FSM and ack alone.
      if (clr_stable) begin
        led     <= '0;
        led_vld <= '0;
      end
    end
  end

  assign led_ack = (ack_cnt != '0);

endmodule
